// File: rtl/ahb_sramc_param.sv
// ahb_sramc_param: AHB-lite slave over BANKS single-port SRAMs.
// Zero-wait writes via a one-entry buffer; optional read wait states.
module ahb_sramc_param #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 2048,
  parameter int BANKS       = 4,
  parameter int WAIT_STATES = 0
) (
  input  logic                       hclk,
  input  logic                       hreset_n,
  input  logic                       hsel,
  input  logic [31:0]                haddr,
  input  logic [1:0]                 htrans,
  input  logic                       hwrite,
  input  logic [2:0]                 hsize,
  input  logic [DATA_W-1:0]          hwdata,
  input  logic                       hready,
  output logic [DATA_W-1:0]          hrdata,
  output logic                       hready_resp,
  output logic                       hresp,
  output logic [BANKS-1:0]           sram_csn,
  output logic                       sram_wen,
  output logic [DATA_W/8-1:0]        sram_bwen,
  output logic [$clog2(DEPTH)-1:0]   sram_addr,
  output logic [DATA_W-1:0]          sram_wdata,
  input  logic [BANKS*DATA_W-1:0]    sram_rdata
);

  localparam int NB     = DATA_W / 8;
  localparam int LANE_W = $clog2(NB);
  localparam int WORD_W = $clog2(DEPTH);
  localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam longint unsigned MEM_BYTES =
    longint'(BANKS) * longint'(DEPTH) * longint'(NB);
  localparam logic [1:0] WS_M1 =
    2'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [2:0] {
    IDLE, RDATA, RWAIT, WDATA, ERR1, ERR2
  } state_t;

  state_t state, state_d;
  logic [1:0] wcnt, wcnt_d;

  logic [BANK_W-1:0] a_bank;
  logic [WORD_W-1:0] a_word;
  logic [LANE_W-1:0] a_lane;
  logic [NB-1:0]     a_be;
  logic [6:0]        a_mask;
  logic              a_err;
  logic              ready_st;
  logic              acc;
  logic              launch;

  logic              rd_first;
  logic [BANK_W-1:0] rd_bank;
  logic [WORD_W-1:0] rd_word;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rd_merged;
  logic [DATA_W-1:0] bank_q [BANKS];

  logic [BANK_W-1:0] w_bank;
  logic [WORD_W-1:0] w_word;
  logic [NB-1:0]     w_bwen;
  logic              buf_valid;
  logic [DATA_W-1:0] buf_data;
  logic              hit;
  logic              commit_dir;
  logic              commit_buf;

  logic unused_ok;
  assign unused_ok = htrans[0];

  assign a_lane = haddr[LANE_W-1:0];
  assign a_word = haddr[LANE_W +: WORD_W];
  assign a_bank = (BANKS > 1) ?
    haddr[LANE_W+WORD_W +: BANK_W] : '0;
  assign a_mask = 7'((8'd1 << hsize) - 8'd1);

  assign a_err = (64'(haddr) >= MEM_BYTES)
    || (int'(hsize) > LANE_W)
    || (|(haddr[6:0] & a_mask));

  always_comb begin
    a_be = '0;
    for (int i = 0; i < NB; i++)
      a_be[i] = (i >= int'(a_lane))
        && (i < int'(a_lane) + (1 << hsize));
  end

  assign ready_st = (state == IDLE) || (state == RDATA)
    || (state == WDATA) || (state == ERR2);
  assign acc = hreset_n && ready_st && hsel
    && hready && htrans[1];
  assign launch = acc && !a_err && !hwrite;

  assign hready_resp = ready_st;
  assign hresp = (state == ERR1) || (state == ERR2);

  always_comb begin
    state_d = state;
    wcnt_d  = wcnt;
    unique case (state)
      RWAIT: begin
        if (wcnt == 2'd0) state_d = RDATA;
        else wcnt_d = wcnt - 2'd1;
      end
      ERR1: state_d = ERR2;
      default: begin
        state_d = IDLE;
        if (acc) begin
          if (a_err) state_d = ERR1;
          else if (hwrite) state_d = WDATA;
          else if (WAIT_STATES > 0) begin
            state_d = RWAIT;
            wcnt_d  = WS_M1;
          end else state_d = RDATA;
        end
      end
    endcase
  end

  for (genvar k = 0; k < BANKS; k++) begin : g_bank
    assign bank_q[k] = sram_rdata[k*DATA_W +: DATA_W];
  end

  // Buffered bytes override stale SRAM bytes on a hit
  assign hit = buf_valid && (w_bank == rd_bank)
    && (w_word == rd_word);

  always_comb begin
    rd_merged = bank_q[rd_bank];
    for (int i = 0; i < NB; i++)
      if (hit && !w_bwen[i])
        rd_merged[8*i +: 8] = buf_data[8*i +: 8];
  end

  always_comb begin
    hrdata = '0;
    if (state == RDATA || state == RWAIT)
      hrdata = rd_first ? rd_merged : rdata_q;
  end

  assign commit_dir = (state == WDATA) && !launch;
  assign commit_buf = buf_valid && !launch;

  always_comb begin
    sram_csn   = '1;
    sram_wen   = 1'b1;
    sram_bwen  = '1;
    sram_addr  = '0;
    sram_wdata = '0;
    unique case (1'b1)
      launch: begin
        sram_csn[a_bank] = 1'b0;
        sram_addr        = a_word;
      end
      commit_dir, commit_buf: begin
        sram_csn[w_bank] = 1'b0;
        sram_wen         = 1'b0;
        sram_bwen        = w_bwen;
        sram_addr        = w_word;
        sram_wdata       = commit_dir ? hwdata : buf_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state     <= IDLE;
      wcnt      <= '0;
      rd_first  <= 1'b0;
      rd_bank   <= '0;
      rd_word   <= '0;
      rdata_q   <= '0;
      w_bank    <= '0;
      w_word    <= '0;
      w_bwen    <= '1;
      buf_valid <= 1'b0;
      buf_data  <= '0;
    end else begin
      state    <= state_d;
      wcnt     <= wcnt_d;
      rd_first <= launch;
      if (launch) begin
        rd_bank <= a_bank;
        rd_word <= a_word;
      end
      if (rd_first) rdata_q <= rd_merged;
      if (acc && !a_err && hwrite) begin
        w_bank <= a_bank;
        w_word <= a_word;
        w_bwen <= ~a_be;
      end
      if (state == WDATA && launch) begin
        buf_valid <= 1'b1;
        buf_data  <= hwdata;
      end else if (commit_buf) begin
        buf_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ahb_sramc_param.sv
// tb_ahb_sramc_param: directed + random bus traffic on two instances
// (zero and two read wait states) against a byte-array reference.
module tb_ahb_sramc_param;

  localparam int BANKS = 4;
  localparam int DEPTH = 2048;
  localparam int MEMB  = BANKS * DEPTH * 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  logic        hsel0, hsel1;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        act = 1'b0;
  logic        bus_ready;

  logic [31:0] hrd  [2];
  logic        rdy  [2];
  logic        rsp  [2];
  logic [3:0]  csn  [2];
  logic        wen  [2];
  logic [3:0]  bwen [2];
  logic [10:0] sa   [2];
  logic [31:0] swd  [2];
  logic [31:0] srdw [2][BANKS];

  assign bus_ready = act ? rdy[1] : rdy[0];

  ahb_sramc_param u_dut0 (
    .hclk(clk), .hreset_n(rst_n), .hsel(hsel0), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .hwdata(hwdata), .hready(bus_ready), .hrdata(hrd[0]),
    .hready_resp(rdy[0]), .hresp(rsp[0]), .sram_csn(csn[0]),
    .sram_wen(wen[0]), .sram_bwen(bwen[0]), .sram_addr(sa[0]),
    .sram_wdata(swd[0]),
    .sram_rdata({srdw[0][3], srdw[0][2], srdw[0][1], srdw[0][0]})
  );

  ahb_sramc_param #(.WAIT_STATES(2)) u_dut1 (
    .hclk(clk), .hreset_n(rst_n), .hsel(hsel1), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .hwdata(hwdata), .hready(bus_ready), .hrdata(hrd[1]),
    .hready_resp(rdy[1]), .hresp(rsp[1]), .sram_csn(csn[1]),
    .sram_wen(wen[1]), .sram_bwen(bwen[1]), .sram_addr(sa[1]),
    .sram_wdata(swd[1]),
    .sram_rdata({srdw[1][3], srdw[1][2], srdw[1][1], srdw[1][0]})
  );

  logic [31:0] mem [2][BANKS][DEPTH];
  int          csn_cnt [2][BANKS];
  int          cyc;
  int          last_wr [2];
  int          last_rd [2];
  logic [3:0]  last_bwen [2];

  function automatic logic [31:0] wmerge(
    input logic [31:0] old, input logic [31:0] nw, input logic [3:0] bw);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++)
      if (!bw[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < BANKS; k++) begin
        if (clr) begin
          csn_cnt[d][k] <= 0;
          srdw[d][k] <= '0;
          for (int w = 0; w < DEPTH; w++) mem[d][k][w] <= '0;
        end else if (!csn[d][k]) begin
          csn_cnt[d][k] <= csn_cnt[d][k] + 1;
          if (!wen[d]) begin
            mem[d][k][sa[d]] <= wmerge(mem[d][k][sa[d]], swd[d], bwen[d]);
            last_wr[d] <= cyc;
            last_bwen[d] <= bwen[d];
          end else begin
            srdw[d][k] <= mem[d][k][sa[d]];
            last_rd[d] <= cyc;
          end
        end
      end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  typedef struct {
    bit          idle;
    bit          wr;
    logic [31:0] a;
    logic [2:0]  sz;
    logic [31:0] wd;
  } op_t;

  op_t q[$];
  logic [7:0] refm [2][MEMB];

  function automatic bit is_err(input op_t o);
    return (o.a >= 32'(MEMB)) || (o.sz > 3'd2)
      || ((o.a % (32'd1 << o.sz)) != 0);
  endfunction

  function automatic logic [31:0] ref_word(input int d, input logic [31:0] a);
    logic [31:0] w;
    int base = int'(a) & ~3;
    for (int b = 0; b < 4; b++) w[8*b +: 8] = refm[d][base+b];
    return w;
  endfunction

  task automatic ref_write(input int d, input op_t o);
    int lane = int'(o.a) % 4;
    for (int b = 0; b < (1 << o.sz); b++)
      refm[d][int'(o.a)+b] = o.wd[8*(lane+b) +: 8];
  endtask

  task automatic bus_idle();
    hsel0 = 1'b0; hsel1 = 1'b0; htrans = 2'b00;
    haddr = '0; hwrite = 1'b0; hsize = '0; hwdata = '0;
  endtask

  task automatic complete(input int d, input op_t o, input int waits);
    bit e = !o.idle && is_err(o);
    int ew = o.idle ? 0 : e ? 1 : o.wr ? 0 : (d == 1 ? 2 : 0);
    chk("waits", 32'(waits), 32'(ew));
    chk("hresp", 32'(rsp[d]), 32'(e));
    if (!o.idle && !e && !o.wr)
      chk("rdata", hrd[d], ref_word(d, o.a));
    else
      chk("rdata_zero", hrd[d], 32'd0);
    if (!o.idle && !e && o.wr) ref_write(d, o);
  endtask

  // Pipelined AHB master: caller is at posedge+1
  task automatic run(input int d);
    int idx = 0;
    bit dpv = 0;
    op_t dp;
    int waits = 0;
    bit r;
    act = (d == 1);
    while (idx < q.size() || dpv) begin
      if (idx < q.size() && !q[idx].idle) begin
        hsel0 = (d == 0); hsel1 = (d == 1); htrans = 2'b10;
        haddr = q[idx].a; hwrite = q[idx].wr; hsize = q[idx].sz;
      end else begin
        hsel0 = 1'b0; hsel1 = 1'b0; htrans = 2'b00;
        haddr = '0; hwrite = 1'b0; hsize = '0;
      end
      hwdata = (dpv && !dp.idle && dp.wr) ? dp.wd : '0;
      @(negedge clk);
      r = bus_ready;
      if (dpv && r) complete(d, dp, waits);
      if (dpv && !r) begin
        waits++;
        if (waits > 8) begin
          checks++;
          failures++;
          $error("FAIL timeout obs=%0d exp<=8", waits);
          bus_idle();
          q.delete();
          @(posedge clk); #1;
          return;
        end
      end
      @(posedge clk); #1;
      if (r) begin
        waits = 0;
        dpv = (idx < q.size());
        if (dpv) begin
          dp = q[idx];
          idx++;
        end
      end
    end
    bus_idle();
    q.delete();
  endtask

  function automatic op_t mk(input bit wr, input logic [31:0] a,
                             input logic [2:0] sz, input logic [31:0] wd);
    op_t o;
    o.idle = 0; o.wr = wr; o.a = a; o.sz = sz; o.wd = wd;
    return o;
  endfunction

  function automatic op_t idle_op();
    op_t o = mk(0, 32'd0, 3'd0, 32'd0);
    o.idle = 1;
    return o;
  endfunction

  function automatic op_t rnd_op();
    op_t o;
    int r = $urandom_range(0, 15);
    int bank = $urandom_range(0, 3);
    int word = $urandom_range(0, 7);
    o.idle = (r == 0);
    o.wr = 1'($urandom_range(0, 1));
    o.sz = 3'($urandom_range(0, 2));
    o.wd = $urandom;
    o.a = 32'((bank << 13) | (word << 2)
      | ($urandom_range(0, 3) & ~((1 << o.sz) - 1)));
    if (r == 1) o.a = 32'h8000 + 32'($urandom_range(0, 255) << 2);
    if (r == 2) o.a = 32'hFFFF_FFFC;
    if (r == 3) o.sz = 3'd3;
    if (r == 4) begin
      o.sz = 3'($urandom_range(1, 2));
      o.a = o.a | 32'd1;
    end
    return o;
  endfunction

  function automatic int csn_sum(input int d);
    int s = 0;
    for (int k = 0; k < BANKS; k++) s += csn_cnt[d][k];
    return s;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < MEMB; i++) refm[d][i] = 8'h00;

    // Active request during reset must not reach the SRAM
    bus_idle();
    hsel0 = 1'b1; htrans = 2'b10; haddr = 32'h10; hsize = 3'd2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hready", 32'(rdy[0]), 32'd1);
    chk("rst_hresp", 32'(rsp[0]), 32'd0);
    chk("rst_hrdata", hrd[0], 32'd0);
    chk("rst_csn", 32'(csn[0]), 32'hF);
    chk("rst_wen", 32'(wen[0]), 32'd1);
    chk("rst_bwen", 32'(bwen[0]), 32'hF);
    chk("rst_addr", 32'(sa[0]), 32'd0);
    chk("rst_wdata", swd[0], 32'd0);
    chk("rst_csn1", 32'(csn[1]), 32'hF);
    bus_idle();
    clr = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Write, idle, read back
    c0 = csn_cnt[0][0];
    q.push_back(mk(1, 32'h10, 3'd2, 32'h1234_5678));
    q.push_back(idle_op());
    q.push_back(mk(0, 32'h10, 3'd2, 32'd0));
    run(0);
    chk("csn0_per_access", 32'(csn_cnt[0][0] - c0), 32'd2);

    // Back-to-back write then read: forwarded, commit in read data phase
    q.push_back(mk(1, 32'h20, 3'd2, 32'hAABB_CCDD));
    q.push_back(mk(0, 32'h20, 3'd2, 32'd0));
    run(0);
    chk("commit_after_read", 32'(last_wr[0]), 32'(last_rd[0] + 1));

    // Byte write over existing word
    q.push_back(mk(1, 32'h20, 3'd2, 32'h1122_3344));
    q.push_back(idle_op());
    q.push_back(mk(1, 32'h21, 3'd0, 32'h0000_EE00));
    q.push_back(idle_op());
    q.push_back(mk(0, 32'h20, 3'd2, 32'd0));
    run(0);
    chk("byte_bwen", 32'(last_bwen[0]), 32'hD);

    // Two wait states on a bank 3 read
    q.push_back(mk(1, 32'h6040, 3'd2, 32'h5A5A_0F0F));
    q.push_back(idle_op());
    run(1);
    c0 = csn_cnt[1][3];
    q.push_back(mk(0, 32'h6040, 3'd2, 32'd0));
    run(1);
    chk("csn3_once", 32'(csn_cnt[1][3] - c0), 32'd1);

    // Errors: out of range and misaligned halfword
    c0 = csn_sum(0);
    q.push_back(mk(0, 32'h8000, 3'd2, 32'd0));
    q.push_back(mk(1, 32'h1, 3'd1, 32'hFFFF_FFFF));
    q.push_back(mk(0, 32'h0, 3'd3, 32'd0));
    run(0);
    chk("err_no_csn", 32'(csn_sum(0) - c0), 32'd0);

    // Reset in the write data phase discards the write
    q.push_back(mk(1, 32'h40, 3'd2, 32'hCAFE_F00D));
    q.push_back(idle_op());
    run(0);
    hsel0 = 1'b1; htrans = 2'b10; haddr = 32'h40;
    hwrite = 1'b1; hsize = 3'd2;
    @(posedge clk); #1;
    hsel0 = 1'b0; htrans = 2'b00; haddr = '0; hwrite = 1'b0;
    hwdata = 32'hDEAD_BEEF;
    #1;
    chk("wdata_phase_wen", 32'(wen[0]), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_hready", 32'(rdy[0]), 32'd1);
    chk("mid_hresp", 32'(rsp[0]), 32'd0);
    chk("mid_hrdata", hrd[0], 32'd0);
    chk("mid_csn", 32'(csn[0]), 32'hF);
    chk("mid_wen", 32'(wen[0]), 32'd1);
    chk("mid_bwen", 32'(bwen[0]), 32'hF);
    chk("mid_addr", 32'(sa[0]), 32'd0);
    chk("mid_wdata", swd[0], 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus_idle();
    rst_n = 1'b1;
    @(posedge clk); #1;
    q.push_back(mk(0, 32'h40, 3'd2, 32'd0));
    run(0);

    // Random traffic on both instances
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 150; i++) q.push_back(rnd_op());
      run(d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
